// File: rtl/fft_agu_pkg.sv
// Shared types and sizing helpers for the FFT address-generation sequencer.
// FFT_AGU_BITREV_LOAD_EN (in the top) enables the bit-reversed input-reorder pass.
package fft_agu_pkg;

    localparam int MDATAW_DEF = 8;
    localparam int FFTSIZ_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } agu_state_e;

    function automatic int fft_len(input int logn);
        return 1 << logn;
    endfunction

    function automatic int fft_half(input int logn);
        return 1 << (logn - 1);
    endfunction

    function automatic int stage_width(input int logn);
        return $clog2(logn) + 1;
    endfunction

endpackage

// File: rtl/fft_agu_bit_rev.sv
// Combinational bit reversal of a W-bit index; shared with the inverse-addressing path.
module bit_rev #(
    parameter int W = 3
) (
    input  logic [W-1:0] idx_i,
    output logic [W-1:0] rev_o
);

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign rev_o[i] = idx_i[W-1-i];
    end

endmodule

// File: rtl/fft_agu.sv
// Radix-2 DIT FFT address sequencer: one butterfly address pair + twiddle per accepted beat.
// Build option FFT_AGU_BITREV_LOAD_EN adds a LOAD pass emitting the bit-reverse reorder beats.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | bit-reverse reorder beats (only with FFT_AGU_BITREV_LOAD_EN)
// RUN   | butterfly beats, stage by stage
// FIN   | one-cycle done pulse
module fft_agu
    import fft_agu_pkg::*;
#(
    parameter int MDATAW = MDATAW_DEF,
    parameter int FFTSIZ = FFTSIZ_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    input  logic [MDATAW-1:0]                   base_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                out_vld_o,
    input  logic                                out_rdy_i,
    output logic [MDATAW-1:0]                   addr_a_o,
    output logic [MDATAW-1:0]                   addr_b_o,
    output logic [FFTSIZ-2:0]                   tw_idx_o,
    output logic [stage_width(FFTSIZ)-1:0]      stage_o,
    output logic                                last_o
);

    localparam int N    = fft_len(FFTSIZ);
    localparam int HALF = fft_half(FFTSIZ);
    localparam int SW   = stage_width(FFTSIZ);
    localparam int KW   = FFTSIZ - 1;

    agu_state_e          state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [KW-1:0]       k_q, k_d;
    logic [MDATAW-1:0]   base_q, base_d;
    logic [MDATAW-1:0]   addr_a_q, addr_a_d;
    logic [MDATAW-1:0]   addr_b_q, addr_b_d;
    logic [KW-1:0]       tw_q, tw_d;
    logic [SW-1:0]       stg_q, stg_d;
    logic                last_q, last_d;
    logic                upd;
    logic                acc;

    logic [FFTSIZ-1:0]   kx, span, pos, grp, ia, ib;
    logic [FFTSIZ-1:0]   off_a, off_b;

`ifdef FFT_AGU_BITREV_LOAD_EN
    logic [FFTSIZ-1:0]   j_q, j_d;
    logic [FFTSIZ-1:0]   j_rev;

    bit_rev #(.W(FFTSIZ)) u_bit_rev (
        .idx_i (j_d),
        .rev_o (j_rev)
    );

    assign acc = ((state_q == ST_RUN) || (state_q == ST_LOAD)) && out_rdy_i;
`else
    assign acc = (state_q == ST_RUN) && out_rdy_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            k_q      <= '0;
            base_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stg_q    <= '0;
            last_q   <= 1'b0;
`ifdef FFT_AGU_BITREV_LOAD_EN
            j_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            base_q  <= base_d;
            last_q  <= last_d;
`ifdef FFT_AGU_BITREV_LOAD_EN
            j_q     <= j_d;
`endif
            if (upd) begin
                addr_a_q <= addr_a_d;
                addr_b_q <= addr_b_d;
                tw_q     <= tw_d;
                stg_q    <= stg_d;
            end
        end
    end

    // Counters advance on acceptance; upd loads the next beat into the output registers.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        base_d  = base_q;
        upd     = 1'b0;
`ifdef FFT_AGU_BITREV_LOAD_EN
        j_d     = j_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d = base_i;
                    s_d    = '0;
                    k_d    = '0;
                    upd    = 1'b1;
`ifdef FFT_AGU_BITREV_LOAD_EN
                    j_d     = '0;
                    state_d = ST_LOAD;
`else
                    state_d = ST_RUN;
`endif
                end
            end
`ifdef FFT_AGU_BITREV_LOAD_EN
            ST_LOAD: begin
                if (acc) begin
                    upd = 1'b1;
                    if (j_q == FFTSIZ'(N - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        j_d = j_q + FFTSIZ'(1);
                    end
                end
            end
`endif
            ST_RUN: begin
                if (acc) begin
                    if (k_q == KW'(HALF - 1)) begin
                        k_d = '0;
                        if (s_q == SW'(FFTSIZ - 1)) begin
                            state_d = ST_FIN;
                        end else begin
                            s_d = s_q + SW'(1);
                            upd = 1'b1;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                        upd = 1'b1;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat contents for the upcoming (s_d, k_d): ia = grp*2*span + pos, ib = ia + span.
    always_comb begin
        kx    = {1'b0, k_d};
        span  = FFTSIZ'(1) << s_d;
        pos   = kx & (span - FFTSIZ'(1));
        grp   = kx >> s_d;
        ia    = (grp << (s_d + SW'(1))) | pos;
        ib    = ia + span;
        off_a = ia;
        off_b = ib;
        tw_d  = KW'(pos << (SW'(FFTSIZ - 1) - s_d));
        stg_d = s_d;
`ifdef FFT_AGU_BITREV_LOAD_EN
        if (state_d == ST_LOAD) begin
            off_a = j_rev;
            off_b = j_d;
            tw_d  = '0;
            stg_d = '0;
        end
`endif
        addr_a_d = base_d + MDATAW'(off_a);
        addr_b_d = base_d + MDATAW'(off_b);
        last_d   = (state_d == ST_RUN) && (s_d == SW'(FFTSIZ - 1)) && (k_d == KW'(HALF - 1));
    end

    always_comb begin
`ifdef FFT_AGU_BITREV_LOAD_EN
        busy_o    = (state_q == ST_RUN) || (state_q == ST_LOAD);
`else
        busy_o    = (state_q == ST_RUN);
`endif
        out_vld_o = busy_o;
        done_o    = (state_q == ST_FIN);
        addr_a_o  = addr_a_q;
        addr_b_o  = addr_b_q;
        tw_idx_o  = tw_q;
        stage_o   = stg_q;
        last_o    = last_q;
    end

endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu against a loop-based model of the DIT butterfly schedule.
module tb_fft_agu;

    localparam int MDATAW = 8;
    localparam int FFTSIZ = 3;
    localparam int N      = 8;
    localparam int HALF   = 4;
`ifdef FFT_AGU_BITREV_LOAD_EN
    localparam int LOADB  = N;
`else
    localparam int LOADB  = 0;
`endif
    localparam int TOTAL  = LOADB + FFTSIZ * HALF;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] t;
        logic [2:0] s;
        logic       l;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  base_i;
    logic        busy_o, done_o, out_vld_o, out_rdy_i, last_o;
    logic [7:0]  addr_a_o, addr_b_o;
    logic [1:0]  tw_idx_o;
    logic [2:0]  stage_o;

    beat_t act_q[$];
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stall_viol, vld_cycles, done_cnt, done_gap, first_vld;
    bit    timed_out;

    fft_agu #(.MDATAW(MDATAW), .FFTSIZ(FFTSIZ)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .base_i    (base_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .addr_a_o  (addr_a_o),
        .addr_b_o  (addr_b_o),
        .tw_idx_o  (tw_idx_o),
        .stage_o   (stage_o),
        .last_o    (last_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected beat list: reorder pass (if built) then stages, walking groups of 2*span words.
    task automatic build_model(input logic [7:0] base_v);
        exp_q.delete();
`ifdef FFT_AGU_BITREV_LOAD_EN
        for (int j = 0; j < N; j++) begin
            int r = 0;
            for (int i = 0; i < FFTSIZ; i++) r = r * 2 + ((j >> i) & 1);
            exp_q.push_back('{a: 8'((base_v + r) % 256), b: 8'((base_v + j) % 256), t: 2'd0, s: 3'd0, l: 1'b0});
        end
`endif
        for (int s = 0; s < FFTSIZ; s++) begin
            int span = 1 << s;
            int ngrp = N / (2 * span);
            for (int g = 0; g < ngrp; g++) begin
                for (int p = 0; p < span; p++) begin
                    int ia = g * 2 * span + p;
                    exp_q.push_back('{a: 8'((base_v + ia) % 256),
                                      b: 8'((base_v + ia + span) % 256),
                                      t: 2'(p * ngrp),
                                      s: 3'(s),
                                      l: 1'((s == FFTSIZ - 1) && (g == ngrp - 1) && (p == span - 1))});
                end
            end
        end
    endtask

    // Runs one transform; mode 0 = always ready, 1 = ready toggles from 0, 2 = random ready.
    task automatic collect(input logic [7:0] base_v, input int mode, input bit poke, input int abort_at);
        beat_t cur;
        beat_t held;
        bit    prev_stall = 0;
        bit    rdy_t = 0;
        bit    rdy;
        bit    fin = 0;
        int    cyc = 0;
        int    last_cyc = -1;
        act_q.delete();
        stall_viol = 0; vld_cycles = 0; done_cnt = 0; done_gap = -1; first_vld = -1; timed_out = 0;
        held = '0;
        @(negedge clk_i);
        base_i = base_v; start_i = 1'b1; out_rdy_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        while (!fin) begin
            cur = '{a: addr_a_o, b: addr_b_o, t: tw_idx_o, s: stage_o, l: last_o};
            if (prev_stall && cur !== held) stall_viol++;
            prev_stall = 0;
            start_i = 1'b0;
            if (done_o) begin
                done_cnt++;
                done_gap = cyc - last_cyc;
                if (poke) start_i = 1'b1;
                fin = 1;
            end else if (out_vld_o) begin
                if (first_vld < 0) first_vld = cyc;
                vld_cycles++;
                if (abort_at >= 0 && act_q.size() == abort_at) begin
                    fin = 1;
                end else begin
                    case (mode)
                        0: rdy = 1'b1;
                        1: begin rdy = rdy_t; rdy_t = !rdy_t; end
                        default: rdy = 1'($urandom_range(0, 1));
                    endcase
                    out_rdy_i = rdy;
                    if (rdy) begin
                        act_q.push_back(cur);
                        if (cur.l) last_cyc = cyc;
                    end else begin
                        prev_stall = 1;
                        held = cur;
                    end
                    if (poke && act_q.size() == 3) start_i = 1'b1;
                end
            end
            if (!fin) begin
                if (cyc >= 1000) begin
                    timed_out = 1;
                    fin = 1;
                end else begin
                    @(negedge clk_i);
                    cyc++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; base_i = 8'h00; out_rdy_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, out_vld_o, addr_a_o, addr_b_o, tw_idx_o, stage_o, last_o} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got busy=%b done=%b vld=%b a=%h b=%h t=%0d s=%0d l=%b expected all zero",
                     busy_o, done_o, out_vld_o, addr_a_o, addr_b_o, tw_idx_o, stage_o, last_o);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, out_vld_o, last_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b vld=%b last=%b expected 0000", busy_o, done_o, out_vld_o, last_o);
        end
    endtask

    task automatic test_nominal();
        int ta[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int tb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int tt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        build_model(8'h10);
        collect(8'h10, 0, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL nominal_timeout: no done within budget"); end
        checks++;
        if (first_vld !== 0) begin errors++; $display("FAIL nominal_latency: got first vld cycle %0d expected 0", first_vld); end
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL nominal_count: got %0d beats expected %0d", act_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL nominal_beat[%0d]: got a=%h b=%h t=%0d s=%0d l=%b expected a=%h b=%h t=%0d s=%0d l=%b", i,
                         act_q[i].a, act_q[i].b, act_q[i].t, act_q[i].s, act_q[i].l,
                         exp_q[i].a, exp_q[i].b, exp_q[i].t, exp_q[i].s, exp_q[i].l);
            end
        end
        for (int i = 0; i < 12; i++) if (LOADB + i < act_q.size()) begin
            checks++;
            if (act_q[LOADB+i].a !== 8'(16 + ta[i]) || act_q[LOADB+i].b !== 8'(16 + tb[i]) || act_q[LOADB+i].t !== 2'(tt[i])) begin
                errors++;
                $display("FAIL nominal_table[%0d]: got (%h,%h,%0d) expected (%h,%h,%0d)", i,
                         act_q[LOADB+i].a, act_q[LOADB+i].b, act_q[LOADB+i].t, 8'(16 + ta[i]), 8'(16 + tb[i]), tt[i]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_gap !== 1) begin
            errors++; $display("FAIL nominal_done: got count=%0d gap=%0d expected count=1 gap=1", done_cnt, done_gap);
        end
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, out_vld_o} !== 3'b000) begin
            errors++; $display("FAIL nominal_after: got busy=%b done=%b vld=%b expected 000", busy_o, done_o, out_vld_o);
        end
    endtask

`ifdef FFT_AGU_BITREV_LOAD_EN
    task automatic test_load();
        int ra[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        build_model(8'h00);
        collect(8'h00, 0, 0, -1);
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL load_count: got %0d beats expected %0d", act_q.size(), exp_q.size());
        end
        for (int j = 0; j < N; j++) if (j < act_q.size()) begin
            checks++;
            if (act_q[j].a !== 8'(ra[j]) || act_q[j].b !== 8'(j) || act_q[j].t !== 2'd0 || act_q[j].l !== 1'b0) begin
                errors++;
                $display("FAIL load_beat[%0d]: got a=%h b=%h t=%0d l=%b expected a=%h b=%h t=0 l=0",
                         j, act_q[j].a, act_q[j].b, act_q[j].t, act_q[j].l, 8'(ra[j]), 8'(j));
            end
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL load_seq[%0d]: got %h expected %h", i, act_q[i], exp_q[i]);
            end
        end
        @(negedge clk_i);
    endtask
`endif

    task automatic test_backpressure();
        build_model(8'h10);
        collect(8'h10, 1, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL bp_timeout: no done within budget"); end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d beats expected %0d", act_q.size(), exp_q.size());
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes during stall expected 0", stall_viol); end
        checks++;
        if (vld_cycles !== 2 * TOTAL) begin
            errors++; $display("FAIL bp_cycles: got %0d valid cycles expected %0d", vld_cycles, 2 * TOTAL);
        end
        checks++;
        if (done_cnt !== 1 || done_gap !== 1) begin
            errors++; $display("FAIL bp_done: got count=%0d gap=%0d expected 1 and 1", done_cnt, done_gap);
        end
        @(negedge clk_i);
    endtask

    task automatic test_wrap();
        build_model(8'hFC);
        collect(8'hFC, 0, 0, -1);
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL wrap_beat[%0d]: got %h expected %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (act_q.size() !== TOTAL) begin
            errors++; $display("FAIL wrap_count: got %0d beats expected %0d", act_q.size(), TOTAL);
        end else if (act_q[LOADB+2*HALF].a !== 8'hFC || act_q[LOADB+2*HALF].b !== 8'h00) begin
            errors++;
            $display("FAIL wrap_stage2: got a=%h b=%h expected a=fc b=00", act_q[LOADB+2*HALF].a, act_q[LOADB+2*HALF].b);
        end
        @(negedge clk_i);
    endtask

    task automatic test_start_ignored();
        logic [7:0] bv = 8'($urandom_range(0, 255));
        build_model(bv);
        collect(bv, 0, 1, -1);
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ign_beat[%0d]: got %h expected %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (act_q.size() !== exp_q.size() || done_cnt !== 1) begin
            errors++; $display("FAIL ign_count: got beats=%0d done=%0d expected beats=%0d done=1", act_q.size(), done_cnt, exp_q.size());
        end
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if ({busy_o, done_o, out_vld_o} !== 3'b000) begin
            errors++; $display("FAIL ign_no_restart: got busy=%b done=%b vld=%b expected 000", busy_o, done_o, out_vld_o);
        end
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, out_vld_o} !== 3'b000) begin
            errors++; $display("FAIL ign_quiet: got busy=%b done=%b vld=%b expected 000", busy_o, done_o, out_vld_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bv;
        int         at = LOADB + HALF + 2;
        beat_t      cur;
        build_model(8'h10);
        collect(8'h10, 0, 0, at);
        out_rdy_i = 1'b0;
        cur = '{a: addr_a_o, b: addr_b_o, t: tw_idx_o, s: stage_o, l: last_o};
        checks++;
        if (timed_out || cur !== exp_q[at]) begin
            errors++; $display("FAIL mid_point: got %h timeout=%b expected %h", cur, timed_out, exp_q[at]);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, out_vld_o, addr_a_o, addr_b_o, tw_idx_o, stage_o, last_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b vld=%b a=%h b=%h t=%0d s=%0d l=%b expected all zero",
                     busy_o, done_o, out_vld_o, addr_a_o, addr_b_o, tw_idx_o, stage_o, last_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        bv = 8'($urandom_range(0, 255));
        build_model(bv);
        collect(bv, 0, 0, -1);
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL mid_restart_count: got %0d beats expected %0d", act_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL mid_restart[%0d]: got %h expected %h", i, act_q[i], exp_q[i]);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [7:0] bv = 8'($urandom_range(0, 255));
            build_model(bv);
            collect(bv, 2, 0, -1);
            checks++;
            if (timed_out || act_q.size() !== exp_q.size() || stall_viol !== 0 || done_cnt !== 1) begin
                errors++;
                $display("FAIL rand_run%0d: got beats=%0d stall_changes=%0d done=%0d timeout=%b expected %0d/0/1/0",
                         r, act_q.size(), stall_viol, done_cnt, timed_out, exp_q.size());
            end
            foreach (exp_q[i]) if (i < act_q.size()) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand_beat%0d[%0d]: got %h expected %h", r, i, act_q[i], exp_q[i]);
                end
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
`ifdef FFT_AGU_BITREV_LOAD_EN
        test_load();
`endif
        test_backpressure();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_agu.md
Name: fft_agu

Overview:
- Address-generation sequencer for in-place radix-2 DIT FFT on data memory.
- Once started, emits one butterfly address pair plus twiddle index per accepted beat, stage by stage.
- All addresses are relative to a programmable base, using the same base+offset arithmetic as the processor's relative-address path.
- Sits between the processor control and the data-memory/butterfly datapath; lets an FFT run without per-butterfly instruction overhead.

Parameters:
- MDATAW, 8, data-memory address width.
- FFTSIZ, 3, log2 of FFT length N (N = 2^FFTSIZ). Legal range: 2 <= FFTSIZ < MDATAW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- base  in  MDATAW  base address of the N-word buffer; captured when start is accepted.
- busy  out  1  high while a transform sequence is in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.
- out_vld  out  1  address beat valid.
- out_rdy  in  1  consumer accepts the beat when out_vld && out_rdy.
- addr_a  out  MDATAW  upper-wing (even) operand address.
- addr_b  out  MDATAW  lower-wing (odd) operand address.
- tw_idx  out  FFTSIZ-1  twiddle-ROM index.
- stage  out  FFTSIZ-bit-safe count (clog2(FFTSIZ)+1)  current stage number s.
- last  out  1  marks the final beat of the whole transform.

Behaviour:
- States: IDLE, RUN, FIN.
- IDLE -> RUN on start. In the same edge: base is latched, s=0, k=0.
- RUN -> FIN when the beat with s=FFTSIZ-1 and k=N/2-1 is accepted.
- FIN -> IDLE unconditionally after 1 cycle.
- Reset values: state IDLE, busy=0, done=0, out_vld=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, last=0.
- Latency: out_vld rises in the cycle after start is sampled. busy equals (state==RUN). done=1 only in FIN.
- Beat contents for butterfly k (0..N/2-1) at stage s:
  - span = 2^s
  - pos = k & (span-1)
  - grp = k >> s
  - ia = grp*2*span + pos
  - ib = ia + span
  - tw_idx = pos << (FFTSIZ-1-s)
  - addr_a = base+ia, addr_b = base+ib, both truncated to MDATAW bits (wrap-around mod 2^MDATAW permitted, no flag).
- Handshake:
  - While out_vld && !out_rdy, all beat outputs hold stable.
  - On acceptance, k increments. When k==N/2-1, k wraps to 0 and s increments.
  - Back-to-back acceptance gives one beat per cycle.
- Beat count: total FFTSIZ*N/2. last=1 only on the final beat.
- start while busy or in FIN: ignored, no restart.
- Reset mid-transform: immediate return to IDLE, out_vld drops, no done pulse.
- All outputs are registered (no combinational path from out_rdy to outputs other than through state).

Optional Feature:
- Macro: FFT_AGU_BITREV_LOAD_EN.
- Defined:
  - A LOAD state is inserted between IDLE and RUN.
  - LOAD emits N beats j=0..N-1 with addr_a = base + bitrev_FFTSIZ(j), addr_b = base + j, tw_idx=0, stage=0.
  - This performs the input reorder: read from addr_b, write to addr_a.
  - busy is high during LOAD. last is never set in LOAD.
  - Total beats become N + FFTSIZ*N/2.
- Undefined: no LOAD state; the input is assumed already in bit-reversed order.

Decomposition:
- Package fft_agu_pkg:
  - state encoding (IDLE, LOAD, RUN, FIN)
  - localparam helpers: N, HALF = N/2, stage-counter width
- Sub-module bit_rev: parameterised FFTSIZ, combinational index reversal.
  - Instantiated in the LOAD path.
  - Reusable by the relative-address unit's inverse-addressing mode.

Test Plan:
- FFTSIZ=3, base=0x10, out_rdy=1, macro off: 12 beats, all at the listed (addr_a, addr_b, tw_idx) values.
  - Stage 0: (10,11,0), (12,13,0), (14,15,0), (16,17,0).
  - Stage 1: (10,12,0), (11,13,2), (14,16,0), (15,17,2).
  - Stage 2: (10,14,0), (11,15,1), (12,16,2), (13,17,3).
  - last on beat 12; done exactly 1 cycle later; busy low after.
- Backpressure: out_rdy toggles 0/1 each cycle -> identical beat sequence, outputs stable in every stalled cycle, 24 cycles to completion.
- Wrap: base=0xFC, MDATAW=8 -> stage-2 beat 0 gives addr_a=0xFC, addr_b=0x00.
- start pulsed during RUN and during FIN -> ignored; sequence and done unchanged, single done pulse.
- rst asserted at stage 1, k=2 -> outputs at reset values immediately. A new start then begins again at stage 0, k=0.
- Macro on, base=0: 8 load beats with addr_a = 0,4,2,6,1,5,3,7 and addr_b = 0..7, followed by the 12 RUN beats.
